// File: rtl/lcd_char_ctrl.sv
// HD44780-class 8-bit character LCD controller: power-up init, timed bus accesses, cursor tracking.
// Define LCD_AUTOWRAP_EN to insert set-address commands automatically at end of line.
module lcd_char_ctrl #(
  parameter int unsigned COLS           = 16,
  parameter int unsigned ROWS           = 2,
  parameter int unsigned POWERUP_CYC    = 1000,
  parameter int unsigned EN_PULSE_CYC   = 4,
  parameter int unsigned CMD_WAIT_CYC   = 50,
  parameter int unsigned CLEAR_WAIT_CYC = 2000
) (
  input  logic       fpga_clk_i,
  input  logic       fpga_reset_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_enable_o
);
  localparam int unsigned MAX_A   = (POWERUP_CYC > EN_PULSE_CYC) ? POWERUP_CYC : EN_PULSE_CYC;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned COL_W   = $clog2(COLS + 1);

`ifdef LCD_AUTOWRAP_EN
  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_WRAP
  } state_t;
  logic wrap_q, wrap_d;
`else
  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         init_idx_q, init_idx_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               row_q, row_d;
  logic               ready_d, done_d, rs_d, en_d;
  logic [7:0]         data_d;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Next state, next outputs and cursor update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    init_idx_d = init_idx_q;
    col_d      = col_q;
    row_d      = row_q;
    ready_d    = req_ready_o;
    done_d     = init_done_o;
    data_d     = lcd_data_o;
    rs_d       = lcd_rs_o;
    en_d       = 1'b0;
`ifdef LCD_AUTOWRAP_EN
    wrap_d     = wrap_q;
`endif
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == CNT_W'(POWERUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INIT: begin
        data_d  = init_byte(init_idx_q);
        rs_d    = 1'b0;
        state_d = S_SETUP;
      end
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          ready_d = 1'b0;
          data_d  = req_data_i;
          rs_d    = req_rs_i;
          state_d = S_SETUP;
          if (req_rs_i) begin
`ifdef LCD_AUTOWRAP_EN
            if (32'(col_q) + 1 == COLS) begin
              col_d  = '0;
              row_d  = (ROWS > 1) ? ~row_q : 1'b0;
              wrap_d = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
`else
            if (32'(col_q) < COLS) col_d = col_q + COL_W'(1);
`endif
          end else if ((req_data_i != 8'h00) && (req_data_i <= 8'h03)) begin
            col_d = '0;
            row_d = 1'b0;
          end else if (req_data_i[7]) begin
            row_d = (ROWS > 1) ? req_data_i[6] : 1'b0;
            if (32'(req_data_i[5:0]) >= COLS) col_d = COL_W'(COLS - 1);
            else                              col_d = COL_W'(req_data_i[5:0]);
          end
        end
      end
      S_SETUP: begin
        en_d    = 1'b1;
        cnt_d   = CNT_W'(EN_PULSE_CYC - 1);
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        // Clear/home commands need the long execution wait
        if (!lcd_rs_o && (lcd_data_o != 8'h00) && (lcd_data_o <= 8'h03))
          cnt_d = CNT_W'(CLEAR_WAIT_CYC - 1);
        else
          cnt_d = CNT_W'(CMD_WAIT_CYC - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!init_done_o) begin
          if (init_idx_q == 2'd3) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = S_INIT;
          end
`ifdef LCD_AUTOWRAP_EN
        end else if (wrap_q) begin
          wrap_d  = 1'b0;
          state_d = S_WRAP;
`endif
        end else begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef LCD_AUTOWRAP_EN
      S_WRAP: begin
        data_d  = 8'h80 | (row_q ? 8'h40 : 8'h00);
        rs_d    = 1'b0;
        state_d = S_SETUP;
      end
`endif
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge fpga_clk_i or negedge fpga_reset_i) begin
    if (!fpga_reset_i) begin
      state_q      <= S_PWRUP;
      cnt_q        <= '0;
      init_idx_q   <= '0;
      col_q        <= '0;
      row_q        <= 1'b0;
      req_ready_o  <= 1'b0;
      init_done_o  <= 1'b0;
      lcd_data_o   <= '0;
      lcd_rs_o     <= 1'b0;
      lcd_enable_o <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
      wrap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      col_q        <= col_d;
      row_q        <= row_d;
      req_ready_o  <= ready_d;
      init_done_o  <= done_d;
      lcd_data_o   <= data_d;
      lcd_rs_o     <= rs_d;
      lcd_enable_o <= en_d;
`ifdef LCD_AUTOWRAP_EN
      wrap_q       <= wrap_d;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench for lcd_char_ctrl: init sequence, access timing, cursor, wrap and mid-access reset.
module tb_lcd_char_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, lcd_rs, lcd_en;
  logic [7:0] lcd_data;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_char_ctrl #(
    .COLS(16), .ROWS(2), .POWERUP_CYC(10), .EN_PULSE_CYC(2),
    .CMD_WAIT_CYC(5), .CLEAR_WAIT_CYC(20)
  ) dut (
    .fpga_clk_i(clk), .fpga_reset_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rs_i(req_rs), .req_data_i(req_data),
    .init_done_o(init_done), .lcd_data_o(lcd_data),
    .lcd_rs_o(lcd_rs), .lcd_enable_o(lcd_en)
  );

  always #5 clk = ~clk;

  // Bus monitor: records every enable pulse with its rs/data, width and start cycle
  int         cyc = 0;
  logic [8:0] acc_q[$];
  int         pulse_q[$];
  int         rise_q[$];
  int         plen = 0;
  int         fall_cyc = 0;
  int         done_cyc = 0;
  logic       en_prev = 1'b0;
  logic       done_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      acc_q.push_back({lcd_rs, lcd_data});
      rise_q.push_back(cyc);
      plen = 1;
    end else if (lcd_en) begin
      plen++;
    end
    if (!lcd_en && en_prev) begin
      pulse_q.push_back(plen);
      fall_cyc = cyc;
    end
    if (init_done && !done_prev) done_cyc = cyc;
    en_prev   = lcd_en;
    done_prev = init_done;
  end

  task automatic clear_mon();
    acc_q.delete();
    pulse_q.delete();
    rise_q.delete();
  endtask

  // Present a request from a negedge until accepted; returns at the negedge after the accept edge
  task automatic send(input logic rs, input logic [7:0] d, input bit hold, output bit ok);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    if (!hold) req_valid = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_accept: data=%02h not accepted, required acceptance within 500 clocks", d);
    end
  endtask

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: req_ready_o=0 after 500 clocks, required 1", name);
    end
  endtask

  task automatic wait_init(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (init_done) ok = 1'b1;
    end
    @(negedge clk);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: init_done_o=0 after 3000 clocks, required 1", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, init_done, lcd_rs, lcd_en, lcd_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b done=%b rs=%b en=%b data=%02h, required all 0",
               req_ready, init_done, lcd_rs, lcd_en, lcd_data);
    end
    clear_mon();
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [7:0] exp_b[4];
    exp_b = '{8'h38, 8'h0C, 8'h06, 8'h01};
    wait_init("init_done_rise");
    n_tests++;
    if (acc_q.size() != 4) begin
      n_fail++;
      $display("FAIL init_count: %0d accesses, required 4", acc_q.size());
    end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      n_tests++;
      if (acc_q[i] !== {1'b0, exp_b[i]}) begin
        n_fail++;
        $display("FAIL init_byte%0d: rs/data=%03h, required %03h", i, acc_q[i], {1'b0, exp_b[i]});
      end
      n_tests++;
      if (pulse_q[i] != 2) begin
        n_fail++;
        $display("FAIL init_pulse%0d: width %0d, required 2", i, pulse_q[i]);
      end
    end
    n_tests++;
    if (done_cyc - fall_cyc != 21) begin
      n_fail++;
      $display("FAIL init_clear_wait: done %0d clocks after enable fall, required 21", done_cyc - fall_cyc);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_ready: req_ready_o=%b, required 1", req_ready);
    end
  endtask

  task automatic test_char_timing();
    bit ok;
    send(1'b1, 8'h48, 1'b0, ok);
    n_tests++;
    if ({lcd_rs, lcd_data, lcd_en, req_ready} !== {1'b1, 8'h48, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL char_setup: rs=%b data=%02h en=%b ready=%b, required 1 48 0 0",
               lcd_rs, lcd_data, lcd_en, req_ready);
    end
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      n_tests++;
      if (lcd_en !== ((j == 1) || (j == 2)) || req_ready !== (j == 9) || lcd_data !== 8'h48) begin
        n_fail++;
        $display("FAIL char_timing_T+%0d: en=%b ready=%b data=%02h, required en=%b ready=%b data=48",
                 j + 1, lcd_en, req_ready, lcd_data, (j == 1) || (j == 2), j == 9);
      end
    end
    n_tests++;
    if (int'(dut.col_q) != 1) begin
      n_fail++;
      $display("FAIL char_cursor: col=%0d, required 1", dut.col_q);
    end
  endtask

  task automatic test_clear();
    bit ok;
    send(1'b0, 8'h01, 1'b0, ok);
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      if (j >= 23) begin
        n_tests++;
        if (req_ready !== (j == 24)) begin
          n_fail++;
          $display("FAIL clear_wait_T+%0d: ready=%b, required %b", j + 1, req_ready, j == 24);
        end
      end
    end
    n_tests++;
    if (int'(dut.col_q) != 0 || dut.row_q !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_cursor: col=%0d row=%b, required 0 0", dut.col_q, dut.row_q);
    end
  endtask

  task automatic test_ddram();
    bit ok;
    send(1'b0, 8'hC5, 1'b0, ok);
    n_tests++;
    if (int'(dut.col_q) != 5 || dut.row_q !== 1'b1) begin
      n_fail++;
      $display("FAIL ddram_c5: col=%0d row=%b, required 5 1", dut.col_q, dut.row_q);
    end
    wait_ready("ddram_ready");
    send(1'b0, 8'hBF, 1'b0, ok);
    n_tests++;
    if (int'(dut.col_q) != 15 || dut.row_q !== 1'b0) begin
      n_fail++;
      $display("FAIL ddram_clamp: col=%0d row=%b, required 15 0", dut.col_q, dut.row_q);
    end
    wait_ready("ddram_ready2");
  endtask

  task automatic test_back_to_back();
    bit ok;
    send(1'b0, 8'h01, 1'b0, ok);
    wait_ready("b2b_clear");
    clear_mon();
    send(1'b1, 8'h41, 1'b1, ok);
    send(1'b1, 8'h42, 1'b1, ok);
    req_valid = 1'b0;
    wait_ready("b2b_ready");
    n_tests++;
    if (rise_q.size() != 2 || rise_q[1] - rise_q[0] != 10) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d pulses, spacing %0d, required 2 pulses spacing 10",
               rise_q.size(), (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : -1);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int n_rs1;
    send(1'b0, 8'h01, 1'b0, ok);
    wait_ready("wrap_clear");
    clear_mon();
`ifdef LCD_AUTOWRAP_EN
    for (int i = 0; i < 16; i++) send(1'b1, 8'(8'h61 + i), 1'b0, ok);
    wait_ready("wrap1_ready");
    n_tests++;
    if (acc_q.size() != 17 || acc_q[acc_q.size()-1] !== 9'h0C0) begin
      n_fail++;
      $display("FAIL wrap_c0: %0d accesses last=%03h, required 17 last=0c0",
               acc_q.size(), acc_q[acc_q.size()-1]);
    end
    n_tests++;
    if (int'(dut.col_q) != 0 || dut.row_q !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_cursor1: col=%0d row=%b, required 0 1", dut.col_q, dut.row_q);
    end
    for (int i = 0; i < 16; i++) send(1'b1, 8'(8'h41 + i), 1'b0, ok);
    wait_ready("wrap2_ready");
    n_tests++;
    if (acc_q.size() != 34 || acc_q[acc_q.size()-1] !== 9'h080) begin
      n_fail++;
      $display("FAIL wrap_80: %0d accesses last=%03h, required 34 last=080",
               acc_q.size(), acc_q[acc_q.size()-1]);
    end
`else
    for (int i = 0; i < 17; i++) send(1'b1, 8'(8'h61 + i), 1'b0, ok);
    wait_ready("nowrap_ready");
    n_rs1 = 0;
    foreach (acc_q[i]) if (acc_q[i][8]) n_rs1++;
    n_tests++;
    if (acc_q.size() != 17 || n_rs1 != 17) begin
      n_fail++;
      $display("FAIL nowrap_count: %0d accesses, %0d rs=1, required 17 and 17", acc_q.size(), n_rs1);
    end
    n_tests++;
    if (int'(dut.col_q) != 16 || dut.row_q !== 1'b0) begin
      n_fail++;
      $display("FAIL nowrap_cursor: col=%0d row=%b, required 16 0", dut.col_q, dut.row_q);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    send(1'b1, 8'h5A, 1'b0, ok);
    @(negedge clk);
    n_tests++;
    if (lcd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: en=%b, required 1", lcd_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({lcd_en, req_ready, init_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_async: en=%b ready=%b done=%b, required 0 0 0", lcd_en, req_ready, init_done);
    end
    @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    wait_init("midrst_reinit");
    n_tests++;
    if (acc_q.size() != 4 || acc_q[0] !== 9'h038 || acc_q[3] !== 9'h001) begin
      n_fail++;
      $display("FAIL midrst_sequence: %0d accesses first=%03h, required 4 first=038 last=001",
               acc_q.size(), acc_q[0]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_char_timing();
    test_clear();
    test_ddram();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_char_ctrl.md
# lcd_char_ctrl

Parametrised HD44780-class character LCD controller for the FPGA front panel, driving an 8-bit parallel LCD bus. After reset it runs the power-up delay and a fixed init sequence by itself. It then accepts command and character writes from the page/menu logic over a valid/ready handshake. Every bus access uses the required setup, enable-pulse, hold and execution-wait timing. It tracks the cursor and, optionally, inserts line-wrap address commands automatically.

## Interface
Parameters:
- COLS, 16, characters per line (1..64)
- ROWS, 2, display lines (1 or 2; line base addresses 0x00, 0x40)
- POWERUP_CYC, 1000, clocks held idle after reset before the first init command
- EN_PULSE_CYC, 4, clocks lcd_enable_o stays high per access (≥1)
- CMD_WAIT_CYC, 50, clocks of wait after an ordinary access
- CLEAR_WAIT_CYC, 2000, clocks of wait after clear/home (rs=0, data 0x01..0x03)

Ports:
- fpga_clk_i  in  1  single clock; all logic on its rising edge
- fpga_reset_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  write request present
- req_ready_o  out  1  controller can accept a request
- req_rs_i  in  1  0 = command, 1 = character data
- req_data_i  in  8  command byte or character code
- init_done_o  out  1  init sequence complete; sticky until reset
- lcd_data_o  out  8  LCD DB7..DB0
- lcd_rs_o  out  1  LCD register select
- lcd_enable_o  out  1  LCD E strobe

## Operation
- Reset (async assert, sync release): all outputs 0; state PWRUP; cursor col=0, row=0.
- PWRUP: count POWERUP_CYC clocks, then go to INIT.
- INIT: issues 0x38 (8-bit, 2-line, 5x8), 0x0C (display on, cursor off), 0x06 (increment, no shift) and 0x01 (clear), all with rs=0. Each uses the full access sequence below. After the clear wait completes, init_done_o=1 and the FSM goes to IDLE.
- IDLE: req_ready_o=1. A request is accepted when req_valid_i && req_ready_o at a rising edge. The byte and rs are latched, and req_ready_o drops on that same edge.
- Access sequence, common to user, init and wrap accesses:
  - SETUP: 1 clock; data and rs driven, enable low.
  - PULSE: EN_PULSE_CYC clocks; enable high.
  - HOLD: 1 clock; enable low, data and rs unchanged.
  - WAIT: CLEAR_WAIT_CYC clocks for rs=0 with data ≤0x03 and ≠0x00; otherwise CMD_WAIT_CYC clocks.
  - The FSM then returns to IDLE or to the next INIT/WRAP step.
- Cursor tracking:
  - A data write increments col.
  - Command 0x01, 0x02 or 0x03 sets col=0, row=0.
  - Command with bit7=1 (set DDRAM address) sets row = data[6] (forced 0 when ROWS=1) and col = min(data[5:0], COLS-1).
  - All other commands leave the cursor unchanged.
- lcd_data_o and lcd_rs_o hold their last value between accesses; lcd_enable_o is 0 outside PULSE.
- Requests presented while req_ready_o=0 are ignored; the requester must hold them.

## Timing
- Accept edge T. Bus data/rs valid from T+1. Enable high over [T+2, T+2+EN_PULSE_CYC). HOLD occupies the next clock. req_ready_o returns at T+3+EN_PULSE_CYC+wait, where wait is CMD_WAIT_CYC or CLEAR_WAIT_CYC.
- Back-to-back requests with valid held high: one access per (3+EN_PULSE_CYC+wait) clocks, no bubbles beyond that.
- The counters are sized to $clog2 of the largest cycle parameter plus 1 and never wrap.
- Reset asserted mid-access: enable drops to 0 asynchronously and the full init sequence reruns.

## Configuration
- LCD_AUTOWRAP_EN defined:
  - A data write that leaves col==COLS triggers state WRAP. col becomes 0 and row becomes (row+1) mod ROWS.
  - WRAP issues command 0x80|base(row) with CMD_WAIT_CYC wait, and req_ready_o stays 0 until it completes.
  - With ROWS=1, wrap returns to address 0x80.
- LCD_AUTOWRAP_EN undefined: no WRAP state and no inserted commands. col saturates at COLS; the cursor still tracks.

## Test plan
- Reset release, POWERUP_CYC=10, EN_PULSE_CYC=2, CMD_WAIT_CYC=5, CLEAR_WAIT_CYC=20 -> bus bytes 0x38, 0x0C, 0x06, 0x01 (rs=0) in order. Each has a 2-clock enable pulse. init_done_o rises after the 20-clock clear wait.
- After init, write rs=1 0x48 at edge T -> lcd_data_o=0x48 at T+1, enable high at T+2..T+3, req_ready_o=1 at T+10.
- rs=0 0x01 accepted -> req_ready_o returns 20 clocks after HOLD, not 5; cursor reads col=0, row=0.
- With LCD_AUTOWRAP_EN, COLS=16, ROWS=2: send 16 characters -> after the 16th, an inserted rs=0 0xC0 access appears before ready. 16 more characters -> inserted 0x80.
- Without LCD_AUTOWRAP_EN: same 17 characters -> exactly 17 rs=1 accesses and no rs=0 access.
- Drive fpga_reset_i low while enable is high -> lcd_enable_o=0, req_ready_o=0 and init_done_o=0 immediately. After release, the init sequence repeats from 0x38.
